// File: rtl/hex_display_scheduler_if.sv
// Host-side bundle for the hex display scheduler: update request, masks,
// visible segments and status.
interface hex_display_scheduler_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     blank_mask;
    logic [DIGITS-1:0]     blink_mask;
    logic [7*DIGITS-1:0]   seg_out;
    logic                  busy;
    logic                  done;

    modport master (
        output load, value, blank_mask, blink_mask,
        input  seg_out, busy, done
    );

    modport slave (
        input  load, value, blank_mask, blink_mask,
        output seg_out, busy, done
    );
endinterface

// File: rtl/hex_display_scheduler.sv
// Time-shares one external hex-to-7-segment converter across DIGITS positions,
// captures into shadow registers and commits all digits at once, with blank/blink.
module hex_display_scheduler #(
    parameter int DIGITS    = 4,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    hex_display_scheduler_if.slave  bus,
    output logic [3:0]              conv_nibble,
    input  logic [6:0]              conv_seg
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2(BLINK_DIV);
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    state_t              state;
    logic [IW-1:0]       idx;
    logic [3:0]          nib_q   [DIGITS];
    logic [6:0]          shadow  [DIGITS];
    logic [6:0]          visible [DIGITS];
    logic [DIGITS-1:0]   blank_pend;
    logic [DIGITS-1:0]   blink_pend;
    logic [DIGITS-1:0]   blank_act;
    logic [DIGITS-1:0]   blink_act;
    logic                busy_q;
    logic                done_q;
    logic [CW-1:0]       blink_cnt;
    logic                blink_phase;
    logic [7*DIGITS-1:0] seg_comb;

    // Nibble store is pure data; it is only read after a load has refilled it.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.load) begin
            for (int i = 0; i < DIGITS; i++) begin
                nib_q[i] <= bus.value[4*i +: 4];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            conv_nibble <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            blank_pend  <= '0;
            blink_pend  <= '0;
            blank_act   <= '0;
            blink_act   <= '0;
            for (int i = 0; i < DIGITS; i++) begin
                shadow[i]  <= 7'h7F;
                visible[i] <= 7'h7F;
            end
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        blank_pend  <= bus.blank_mask;
                        blink_pend  <= bus.blink_mask;
                        idx         <= '0;
                        conv_nibble <= bus.value[3:0];
                        busy_q      <= 1'b1;
                        state       <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    // conv_nibble was set one edge earlier, so conv_seg has settled.
                    shadow[idx] <= conv_seg;
                    if (idx == LAST_IDX) begin
                        state <= COMMIT;
                    end else begin
                        idx         <= idx + 1'b1;
                        conv_nibble <= nib_q[idx + 1'b1];
                    end
                end
                COMMIT: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        visible[i] <= shadow[i];
                    end
                    blank_act <= blank_pend;
                    blink_act <= blink_pend;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    idx       <= '0;
                    state     <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Blink timer runs independently of updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == CNT_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    always_comb begin
        seg_comb = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (blank_act[i] || (blink_act[i] && blink_phase)) begin
                seg_comb[7*i +: 7] = 7'h7F;
            end else begin
                seg_comb[7*i +: 7] = visible[i];
            end
        end
    end

    assign bus.seg_out = seg_comb;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Directed bench for hex_display_scheduler (DIGITS=4, BLINK_DIV=4) with a
// reference hex-to-7-segment converter on the converter port.
module tb_hex_display_scheduler;

    logic        clk;
    logic        rst_n;
    logic [3:0]  conv_nibble;
    logic [6:0]  conv_seg;

    int npass;
    int ntot;
    int tb_edges;
    logic [27:0] exp_disp;
    bit          disp_known;

    hex_display_scheduler_if #(.DIGITS(4)) bus ();

    hex_display_scheduler #(
        .DIGITS    (4),
        .BLINK_DIV (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .conv_nibble (conv_nibble),
        .conv_seg    (conv_seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    always_comb conv_seg = hex7(conv_nibble);

    // Edges since reset release, for the expected blink phase.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_edges <= 0;
        else        tb_edges <= tb_edges + 1;
    end

    typedef struct {
        logic [15:0] value;
        logic [3:0]  blank;
        logic [3:0]  blink;
        logic [27:0] exp;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        ntot++;
        if (got !== want) $display("FAIL %s: got %h want %h", name, got, want);
        else npass++;
    endtask

    task automatic run_update(input logic [15:0] v, input logic [3:0] bm, input logic [3:0] km,
                              input logic [27:0] want, input bit chk_seg, input int glitch_at);
        logic [15:0] vv;
        vv = v;
        @(negedge clk);
        bus.load = 1'b1;
        bus.value = v;
        bus.blank_mask = bm;
        bus.blink_mask = km;
        @(posedge clk);
        @(negedge clk);
        bus.load = 1'b0;
        bus.value = ~v;
        bus.blank_mask = ~bm;
        bus.blink_mask = ~km;
        chk("busy_e0", 32'(bus.busy), 32'd1);
        chk("nib0", 32'(conv_nibble), 32'(vv[3:0]));
        chk("done_e0", 32'(bus.done), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            if (k == glitch_at) begin
                bus.load = 1'b1;
                bus.value = 16'hFFFF;
            end
            @(posedge clk);
            @(negedge clk);
            bus.load = 1'b0;
            if (k <= 3) chk("nib", 32'(conv_nibble), 32'(vv[4*k +: 4]));
            chk("busy", 32'(bus.busy), 32'(k <= 4));
            chk("done", 32'(bus.done), 32'(k == 5));
            if (k <= 4 && disp_known) chk("hold", 32'(bus.seg_out), 32'(exp_disp));
            if (k == 5 && chk_seg) chk("seg", 32'(bus.seg_out), 32'(want));
        end
        if (chk_seg) begin
            exp_disp = want;
            disp_known = 1'b1;
        end else begin
            disp_known = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] d0;
        npass = 0;
        ntot = 0;
        disp_known = 1'b0;
        exp_disp = '1;
        vecs[0] = '{16'h1234, 4'b0000, 4'b0000, {7'h79, 7'h24, 7'h30, 7'h19}};
        vecs[1] = '{16'h0A5F, 4'b1000, 4'b0000, {7'h7F, 7'h08, 7'h12, 7'h0E}};
        vecs[2] = '{16'h89AB, 4'b0000, 4'b0000, {7'h00, 7'h10, 7'h08, 7'h03}};
        vecs[3] = '{16'hCDEF, 4'b0101, 4'b0000, {7'h46, 7'h7F, 7'h06, 7'h7F}};
        vecs[4] = '{16'h0000, 4'b1111, 4'b0000, 28'hFFFFFFF};

        rst_n = 1'b1;
        bus.load = 1'b0;
        bus.value = '0;
        bus.blank_mask = '0;
        bus.blink_mask = '0;

        // Asynchronous reset asserted mid-cycle.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_seg", 32'(bus.seg_out), 32'(28'hFFFFFFF));
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_nib", 32'(conv_nibble), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_disp = 28'hFFFFFFF;
        disp_known = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_update(vecs[i].value, vecs[i].blank, vecs[i].blink, vecs[i].exp, 1'b1, 0);
        end

        // Load pulses while busy (in CAPTURE, then on the commit edge) are ignored.
        run_update(16'h1234, 4'b0000, 4'b0000, {7'h79, 7'h24, 7'h30, 7'h19}, 1'b1, 3);
        run_update(16'h0A5F, 4'b0000, 4'b0000, {7'h40, 7'h08, 7'h12, 7'h0E}, 1'b1, 5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_2nd_done", 32'(bus.done), 32'd0);
            chk("idle_busy", 32'(bus.busy), 32'd0);
        end

        // Blink on digit 0.
        run_update(16'h0008, 4'b0000, 4'b0001, '0, 1'b0, 0);
        for (int i = 0; i < 12; i++) begin
            d0 = (((tb_edges / 4) % 2) == 1) ? 7'h7F : 7'h00;
            chk("blink", 32'(bus.seg_out), 32'({7'h40, 7'h40, 7'h40, d0}));
            @(negedge clk);
        end

        // Reset during capture aborts the update.
        bus.load = 1'b1;
        bus.value = 16'h1234;
        bus.blank_mask = '0;
        bus.blink_mask = '0;
        @(posedge clk);
        @(negedge clk);
        bus.load = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_seg", 32'(bus.seg_out), 32'(28'hFFFFFFF));
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_nib", 32'(conv_nibble), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_done", 32'(bus.done), 32'd0);
            chk("post_rst_seg", 32'(bus.seg_out), 32'(28'hFFFFFFF));
        end
        exp_disp = 28'hFFFFFFF;
        disp_known = 1'b1;
        run_update(16'h5678, 4'b0000, 4'b0000, {7'h12, 7'h02, 7'h78, 7'h00}, 1'b1, 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
